// File: rtl/pd_pkg.sv
// Shared types and constants for the parametrised pattern detector.
package pd_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } pd_state_e;

    // Symbol names inherited from the fixed 5-symbol detector
    localparam logic B = 1'b0;
    localparam logic C = 1'b1;

    localparam logic [4:0] PD_PAT_DEF = {B, B, C, B, C};

endpackage

// File: rtl/pattern_det_param_if.sv
// Symbol stream, configuration and match outputs of the pattern detector.
// match_count exists only when PD_MATCH_CNT_EN is defined.
interface pattern_det_param_if #(
    parameter int unsigned PAT_LEN = 5,
    parameter int unsigned SYM_W   = 1
`ifdef PD_MATCH_CNT_EN
    ,
    parameter int unsigned CNT_W   = 16
`endif
);
    logic                       cfg_load;
    logic [PAT_LEN*SYM_W-1:0]   cfg_pattern;
    logic                       cfg_overlap;
    logic                       valid;
    logic [SYM_W-1:0]           in;
    logic                       out;
`ifdef PD_MATCH_CNT_EN
    logic [CNT_W-1:0]           match_count;
`endif

    modport master (
        output cfg_load, cfg_pattern, cfg_overlap, valid, in,
        input  out
`ifdef PD_MATCH_CNT_EN
        ,
        input  match_count
`endif
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_overlap, valid, in,
        output out
`ifdef PD_MATCH_CNT_EN
        ,
        output match_count
`endif
    );

endinterface

// File: rtl/pd_match_cnt.sv
// Saturating match counter; clr has priority over inc.
module pd_match_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pattern_det_param.sv
// Runtime-loadable PAT_LEN x SYM_W pattern detector on a valid-qualified symbol stream.
// Optional saturating match counter enabled by defining PD_MATCH_CNT_EN.
module pattern_det_param
    import pd_pkg::*;
#(
    parameter int unsigned            PAT_LEN = 5,
    parameter int unsigned            SYM_W   = 1,
    parameter logic [PAT_LEN*SYM_W-1:0] PAT_DEF = PD_PAT_DEF
`ifdef PD_MATCH_CNT_EN
    ,
    parameter int unsigned            CNT_W   = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    pattern_det_param_if.slave bus
);

    localparam int unsigned PAT_W  = PAT_LEN * SYM_W;
    localparam int unsigned HIST_W = (PAT_LEN - 1) * SYM_W;
    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

    pd_state_e          state_q, state_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    // The oldest window slot is shifted out unseen, so only PAT_LEN-1 symbols are held
    logic [HIST_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               out_q;
    logic [PAT_W-1:0]   shifted_c;
    logic               full_c;
    logic               match_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            pattern_q <= PAT_DEF;
            hist_q    <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            out_q     <= match_c;
        end
    end

    // Next state, window shift and comparison
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_c   = 1'b0;
        shifted_c = {hist_q, bus.in};
        full_c    = (state_q == ARMED) || (fill_q == FILL_W'(PAT_LEN - 1));

        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            fill_d    = '0;
            state_d   = FILL;
        end else if (bus.valid) begin
            hist_d = shifted_c[HIST_W-1:0];
            if (full_c) begin
                match_c = (shifted_c == pattern_q);
                if (match_c && !bus.cfg_overlap) begin
                    state_d = FILL;
                    fill_d  = '0;
                end else begin
                    state_d = ARMED;
                    fill_d  = FILL_W'(PAT_LEN);
                end
            end else begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    assign bus.out = out_q;

`ifdef PD_MATCH_CNT_EN
    logic [CNT_W-1:0] count;

    pd_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.cfg_load),
        .inc   (match_c),
        .count (count)
    );

    assign bus.match_count = count;
`endif

endmodule

// File: tb/tb_pattern_det_param.sv
// Scoreboard bench for pattern_det_param: three instances (default, CNT_W=3, SYM_W=2/PAT_LEN=4).
module tb_pattern_det_param;

    logic clk;
    logic rst_a, rst_b, rst_c;

    pattern_det_param_if #(.PAT_LEN(5), .SYM_W(1)) if_a ();
    pattern_det_param_if #(.PAT_LEN(5), .SYM_W(1)
`ifdef PD_MATCH_CNT_EN
        , .CNT_W(3)
`endif
    ) if_b ();
    pattern_det_param_if #(.PAT_LEN(4), .SYM_W(2)) if_c ();

    pattern_det_param #(.PAT_LEN(5), .SYM_W(1)) dut_a (
        .clk (clk), .rst (rst_a), .bus (if_a.slave)
    );
    pattern_det_param #(.PAT_LEN(5), .SYM_W(1), .PAT_DEF(5'b00101)
`ifdef PD_MATCH_CNT_EN
        , .CNT_W(3)
`endif
    ) dut_b (
        .clk (clk), .rst (rst_b), .bus (if_b.slave)
    );
    pattern_det_param #(.PAT_LEN(4), .SYM_W(2), .PAT_DEF(8'h4E)) dut_c (
        .clk (clk), .rst (rst_c), .bus (if_c.slave)
    );

    typedef struct {
        int  d;
        bit  o;
        int  c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   cyc    = 0;

    // Reference model: count fresh symbols and compare the last PAT_LEN of them
    logic [7:0] m_pat [3];
    logic [7:0] m_win [3];
    int         m_n   [3];
    int         m_cnt [3];
    int         plen  [3] = '{5, 5, 4};
    int         symw  [3] = '{1, 1, 2};
    int         cmax  [3] = '{65535, 7, 65535};
    logic [7:0] pdef  [3] = '{8'h05, 8'h05, 8'h4E};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int d, input bit r, input bit ld, input logic [7:0] pat,
                         input bit ovl, input bit v, input logic [1:0] sym);
        exp_t       e;
        bit         obs;
        int         oc;
        logic [7:0] mask;
        mask = 8'((1 << (plen[d] * symw[d])) - 1);

        rst_a = (d == 0) && r;
        rst_b = (d == 1) && r;
        rst_c = (d == 2) && r;
        if_a.cfg_load = 1'b0; if_a.valid = 1'b0;
        if_b.cfg_load = 1'b0; if_b.valid = 1'b0;
        if_c.cfg_load = 1'b0; if_c.valid = 1'b0;
        case (d)
            0: begin
                if_a.cfg_load = ld; if_a.cfg_pattern = pat[4:0]; if_a.cfg_overlap = ovl;
                if_a.valid = v; if_a.in = sym[0];
            end
            1: begin
                if_b.cfg_load = ld; if_b.cfg_pattern = pat[4:0]; if_b.cfg_overlap = ovl;
                if_b.valid = v; if_b.in = sym[0];
            end
            default: begin
                if_c.cfg_load = ld; if_c.cfg_pattern = pat; if_c.cfg_overlap = ovl;
                if_c.valid = v; if_c.in = sym;
            end
        endcase

        e.d = d;
        e.o = 1'b0;
        if (r) begin
            m_pat[d] = pdef[d]; m_win[d] = '0; m_n[d] = 0; m_cnt[d] = 0;
        end else if (ld) begin
            m_pat[d] = pat & mask; m_n[d] = 0; m_cnt[d] = 0;
        end else if (v) begin
            m_win[d] = ((m_win[d] << symw[d]) | 8'(sym)) & mask;
            m_n[d]++;
            if (m_n[d] >= plen[d] && m_win[d] == m_pat[d]) begin
                e.o = 1'b1;
                if (m_cnt[d] < cmax[d]) m_cnt[d]++;
                if (!ovl) m_n[d] = 0;
            end
        end
        e.c = m_cnt[d];
        sb.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        case (e.d)
            0: obs = if_a.out;
            1: obs = if_b.out;
            default: obs = if_c.out;
        endcase
        checks++;
        if (obs !== e.o) begin
            errors++;
            $display("FAIL out dut%0d cycle %0d: got %b expected %b", e.d, cyc, obs, e.o);
        end
        if (obs === 1'b1) pulses++;
`ifdef PD_MATCH_CNT_EN
        case (e.d)
            0: oc = int'(if_a.match_count);
            1: oc = int'(if_b.match_count);
            default: oc = int'(if_c.match_count);
        endcase
        checks++;
        if (oc !== e.c) begin
            errors++;
            $display("FAIL match_count dut%0d cycle %0d: got %0d expected %0d", e.d, cyc, oc, e.c);
        end
`else
        oc = e.c;
`endif
    endtask

    task automatic send(input int d, input bit ovl, input logic [1:0] sym);
        drive(d, 1'b0, 1'b0, 8'h00, ovl, 1'b1, sym);
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
    endtask

    task automatic check_pulses(input string name, input int want);
        checks++;
        if (pulses !== want) begin
            errors++;
            $display("FAIL %s pulses: got %0d expected %0d", name, pulses, want);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
            drive(d, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 2'b11);
            idle(d);
        end
    endtask

    task automatic test_defaults();
        logic [4:0] s;
        s = 5'b00101;
        drive(0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
        pulses = 0;
        for (int i = 4; i >= 0; i--) send(0, 1'b1, {1'b0, s[i]});
        idle(0);
        idle(0);
        check_pulses("defaults", 1);
    endtask

    task automatic test_overlap(input bit ovl, input int want);
        logic [6:0] s;
        s = 7'b1010101;
        drive(0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
        drive(0, 1'b0, 1'b1, 8'h15, ovl, 1'b0, 2'b00);
        pulses = 0;
        for (int i = 6; i >= 0; i--) send(0, ovl, {1'b0, s[i]});
        idle(0);
        check_pulses(ovl ? "overlap" : "no_overlap", want);
    endtask

    task automatic test_gap();
        drive(0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
        pulses = 0;
        send(0, 1'b1, 2'd0); send(0, 1'b1, 2'd0); send(0, 1'b1, 2'd1);
        idle(0); idle(0); idle(0);
        send(0, 1'b1, 2'd0); send(0, 1'b1, 2'd1);
        idle(0);
        check_pulses("gap", 1);
    endtask

    task automatic test_mid_reset();
        drive(0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
        pulses = 0;
        send(0, 1'b1, 2'd0); send(0, 1'b1, 2'd0); send(0, 1'b1, 2'd1); send(0, 1'b1, 2'd0);
        drive(0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1);
        send(0, 1'b1, 2'd1);
        idle(0);
        check_pulses("mid_reset_none", 0);
        send(0, 1'b1, 2'd0); send(0, 1'b1, 2'd0); send(0, 1'b1, 2'd1);
        send(0, 1'b1, 2'd0); send(0, 1'b1, 2'd1);
        idle(0);
        check_pulses("mid_reset_after", 1);
    endtask

    task automatic test_load_drop();
        drive(0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
        pulses = 0;
        send(0, 1'b1, 2'd0); send(0, 1'b1, 2'd0); send(0, 1'b1, 2'd1); send(0, 1'b1, 2'd0);
        drive(0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 2'd1);
        idle(0);
        check_pulses("load_drop", 0);
    endtask

    task automatic test_saturate();
        drive(1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
        drive(1, 1'b0, 1'b1, 8'h15, 1'b1, 1'b0, 2'b00);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            send(1, 1'b1, 2'd1);
            send(1, 1'b1, 2'd0);
        end
        send(1, 1'b1, 2'd1);
        idle(1);
        check_pulses("saturate", 8);
`ifdef PD_MATCH_CNT_EN
        checks++;
        if (if_b.match_count !== 3'd7) begin
            errors++;
            $display("FAIL saturate count: got %0d expected 7", if_b.match_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] p;
        drive(2, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                p = {1'b0, 1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'($urandom)};
                drive(2, 1'b0, 1'b1, p, 1'($urandom), 1'($urandom), 2'($urandom));
            end else if ($urandom_range(0, 99) < 1) begin
                drive(2, 1'b1, 1'b0, 8'h00, 1'b1, 1'($urandom), 2'($urandom));
            end else begin
                drive(2, 1'b0, 1'b0, 8'h00, 1'($urandom),
                      ($urandom_range(0, 99) < 75),
                      ($urandom_range(0, 9) == 0) ? 2'($urandom) : {1'b0, 1'($urandom)});
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        if_a.cfg_load = 1'b0; if_a.cfg_pattern = '0; if_a.cfg_overlap = 1'b1; if_a.valid = 1'b0; if_a.in = '0;
        if_b.cfg_load = 1'b0; if_b.cfg_pattern = '0; if_b.cfg_overlap = 1'b1; if_b.valid = 1'b0; if_b.in = '0;
        if_c.cfg_load = 1'b0; if_c.cfg_pattern = '0; if_c.cfg_overlap = 1'b1; if_c.valid = 1'b0; if_c.in = '0;

        test_reset();
        test_defaults();
        test_overlap(1'b1, 2);
        test_overlap(1'b0, 1);
        test_gap();
        test_mid_reset();
        test_load_drop();
        test_saturate();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
